// File: rtl/pw_match_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and default widths for the USB pattern-match sequencer.
package pw_defines;

    localparam int PW_CNT_WIDTH     = 8;
    localparam int PW_HOLDOFF_WIDTH = 16;
    localparam int PW_TIMEOUT_WIDTH = 32;

    typedef enum logic [1:0] {
        PMS_IDLE    = 2'd0,
        PMS_ARMED   = 2'd1,
        PMS_HOLDOFF = 2'd2,
        PMS_DONE    = 2'd3
    } pms_state_t;

endpackage

// File: rtl/pw_loadable_downcounter.sv
`timescale 1ns/1ps
// Loadable down-counter that saturates at zero; used for holdoff and timeout.
module pw_loadable_downcounter #(
    parameter int WIDTH = 16
) (
    input  logic             fe_clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - ONE;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pw_match_sequencer.sv
`timescale 1ns/1ps
// Arms the USB pattern matcher, counts qualifying match edges with holdoff,
// and fires a sequence trigger after N matches or stops on armed-window timeout.
module pw_match_sequencer
    import pw_defines::*;
#(
    parameter int pCNT_WIDTH     = PW_CNT_WIDTH,
    parameter int pHOLDOFF_WIDTH = PW_HOLDOFF_WIDTH,
    parameter int pTIMEOUT_WIDTH = PW_TIMEOUT_WIDTH
) (
    input  logic                      fe_clk,
    input  logic                      reset_n,
    input  logic                      I_arm_req,
    input  logic                      I_disarm,
    input  logic [pCNT_WIDTH-1:0]     I_match_target,
    input  logic [pHOLDOFF_WIDTH-1:0] I_holdoff_cycles,
    input  logic [pTIMEOUT_WIDTH-1:0] I_timeout_cycles,
    input  logic                      I_auto_rearm,
    input  logic                      I_match,
    output logic                      O_arm,
    output logic                      O_match_clear,
    output logic                      O_seq_trigger,
    output logic [pCNT_WIDTH-1:0]     O_match_cnt,
    output logic                      O_busy,
    output logic                      O_done,
    output logic                      O_timeout
);

    localparam logic [pCNT_WIDTH-1:0]     CNT_ONE = pCNT_WIDTH'(1);
    localparam logic [pCNT_WIDTH-1:0]     CNT_MAX = '1;
    localparam logic [pTIMEOUT_WIDTH-1:0] TO_ONE  = pTIMEOUT_WIDTH'(1);

    pms_state_t state, nxt_state;

    logic                      match_r;
    logic                      match_evt;
    logic                      arm_acc;
    logic                      busy;

    logic [pCNT_WIDTH-1:0]     tgt_q;
    logic [pHOLDOFF_WIDTH-1:0] hold_q;
    logic [pTIMEOUT_WIDTH-1:0] tout_q;
    logic                      to_en_q;
    logic                      rearm_q;

    logic [pCNT_WIDTH-1:0]     new_cnt;
    logic [pCNT_WIDTH-1:0]     nxt_cnt;
    logic                      nxt_clear;
    logic                      nxt_trig;
    logic                      nxt_tout;
    logic                      ho_load;
    logic                      to_reload;

    logic                      ho_zero;
    logic                      to_zero;
    logic                      to_load;
    logic                      to_expire;
    logic [pTIMEOUT_WIDTH-1:0] to_src;
    logic [pTIMEOUT_WIDTH-1:0] to_load_val;

    assign match_evt = I_match & ~match_r;
    assign arm_acc   = I_arm_req & ~I_disarm;
    assign busy      = (state == PMS_ARMED) || (state == PMS_HOLDOFF);
    assign new_cnt   = (O_match_cnt == CNT_MAX) ? O_match_cnt : O_match_cnt + CNT_ONE;

    // Counter is loaded with T-1 so that the armed window spans exactly T busy cycles.
    assign to_src      = arm_acc ? I_timeout_cycles : tout_q;
    assign to_load_val = (to_src == '0) ? '0 : to_src - TO_ONE;
    assign to_load     = arm_acc | to_reload;
    assign to_expire   = busy & to_en_q & to_zero;

    pw_loadable_downcounter #(.WIDTH(pHOLDOFF_WIDTH)) u_holdoff (
        .fe_clk   (fe_clk),
        .reset_n  (reset_n),
        .load     (ho_load),
        .load_val (hold_q),
        .en       (state == PMS_HOLDOFF),
        .zero     (ho_zero)
    );

    pw_loadable_downcounter #(.WIDTH(pTIMEOUT_WIDTH)) u_timeout (
        .fe_clk   (fe_clk),
        .reset_n  (reset_n),
        .load     (to_load),
        .load_val (to_load_val),
        .en       (busy & to_en_q),
        .zero     (to_zero)
    );

    always_comb begin
        nxt_state = state;
        nxt_cnt   = O_match_cnt;
        nxt_clear = 1'b0;
        nxt_trig  = 1'b0;
        nxt_tout  = O_timeout;
        ho_load   = 1'b0;
        to_reload = 1'b0;
        if (I_disarm) begin
            nxt_state = PMS_IDLE;
        end else if (I_arm_req) begin
            nxt_state = PMS_ARMED;
            nxt_cnt   = '0;
            nxt_tout  = 1'b0;
            nxt_clear = (state == PMS_IDLE) || (state == PMS_DONE);
        end else begin
            case (state)
                PMS_ARMED: begin
                    // A completing match beats a simultaneous timeout expiry.
                    if (match_evt) begin
                        nxt_clear = 1'b1;
                        if (new_cnt == tgt_q) begin
                            nxt_trig = 1'b1;
                            if (rearm_q) begin
                                nxt_cnt   = '0;
                                to_reload = 1'b1;
                                ho_load   = 1'b1;
                                nxt_state = PMS_HOLDOFF;
                            end else begin
                                nxt_cnt   = new_cnt;
                                nxt_state = PMS_DONE;
                            end
                        end else begin
                            nxt_cnt   = new_cnt;
                            ho_load   = 1'b1;
                            nxt_state = PMS_HOLDOFF;
                        end
                    end else if (to_expire) begin
                        nxt_state = PMS_DONE;
                        nxt_tout  = 1'b1;
                    end
                end
                PMS_HOLDOFF: begin
                    if (to_expire) begin
                        nxt_state = PMS_DONE;
                        nxt_tout  = 1'b1;
                    end else if (ho_zero) begin
                        nxt_state = PMS_ARMED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PMS_IDLE;
            match_r       <= 1'b0;
            O_match_cnt   <= '0;
            O_match_clear <= 1'b0;
            O_seq_trigger <= 1'b0;
            O_timeout     <= 1'b0;
            O_arm         <= 1'b0;
            O_busy        <= 1'b0;
            O_done        <= 1'b0;
        end else begin
            state         <= nxt_state;
            match_r       <= I_match;
            O_match_cnt   <= nxt_cnt;
            O_match_clear <= nxt_clear;
            O_seq_trigger <= nxt_trig;
            O_timeout     <= nxt_tout;
            O_arm         <= (nxt_state == PMS_ARMED);
            O_busy        <= (nxt_state == PMS_ARMED) || (nxt_state == PMS_HOLDOFF);
            O_done        <= (nxt_state == PMS_DONE);
        end
    end

    // Configuration is frozen for the whole sequence; target 0 behaves as 1.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q   <= CNT_ONE;
            hold_q  <= '0;
            tout_q  <= '0;
            to_en_q <= 1'b0;
            rearm_q <= 1'b0;
        end else if (arm_acc) begin
            tgt_q   <= (I_match_target == '0) ? CNT_ONE : I_match_target;
            hold_q  <= I_holdoff_cycles;
            tout_q  <= I_timeout_cycles;
            to_en_q <= (I_timeout_cycles != '0);
            rearm_q <= I_auto_rearm;
        end
    end

endmodule

// File: tb/tb_pw_match_sequencer.sv
`timescale 1ns/1ps
// Directed bench for pw_match_sequencer with hand-computed expectations.
module tb_pw_match_sequencer;

    logic        fe_clk = 1'b0;
    logic        reset_n;
    logic        I_arm_req, I_disarm, I_auto_rearm, I_match;
    logic [7:0]  I_match_target;
    logic [15:0] I_holdoff_cycles;
    logic [31:0] I_timeout_cycles;
    logic        O_arm, O_match_clear, O_seq_trigger, O_busy, O_done, O_timeout;
    logic [7:0]  O_match_cnt;

    int checks = 0;
    int errors = 0;
    int trig_seen;

    pw_match_sequencer dut (
        .fe_clk           (fe_clk),
        .reset_n          (reset_n),
        .I_arm_req        (I_arm_req),
        .I_disarm         (I_disarm),
        .I_match_target   (I_match_target),
        .I_holdoff_cycles (I_holdoff_cycles),
        .I_timeout_cycles (I_timeout_cycles),
        .I_auto_rearm     (I_auto_rearm),
        .I_match          (I_match),
        .O_arm            (O_arm),
        .O_match_clear    (O_match_clear),
        .O_seq_trigger    (O_seq_trigger),
        .O_match_cnt      (O_match_cnt),
        .O_busy           (O_busy),
        .O_done           (O_done),
        .O_timeout        (O_timeout)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input logic [7:0] tgt, input logic [15:0] ho, input logic [31:0] to, input logic ar);
        I_match_target   = tgt;
        I_holdoff_cycles = ho;
        I_timeout_cycles = to;
        I_auto_rearm     = ar;
    endtask

    task automatic arm();
        I_arm_req = 1'b1;
        step();
        I_arm_req = 1'b0;
    endtask

    task automatic match_pulse();
        I_match = 1'b1;
        step();
        I_match = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        I_arm_req = 1'b0; I_disarm = 1'b0; I_match = 1'b0;
        cfg(8'd0, 16'd0, 32'd0, 1'b0);
        cyc(3);
        chk("rst_arm",  O_arm, 0);
        chk("rst_busy", O_busy, 0);
        chk("rst_done", O_done, 0);
        chk("rst_cnt",  O_match_cnt, 0);
        chk("rst_trig", O_seq_trigger, 0);
        reset_n = 1'b1;
        cyc(2);

        // Basic: target 1, trigger one cycle after match edge
        cfg(8'd1, 16'd0, 32'd0, 1'b0);
        arm();
        chk("b_arm",   O_arm, 1);
        chk("b_flush", O_match_clear, 1);
        chk("b_busy",  O_busy, 1);
        cyc(8);
        I_match = 1'b1;
        step();
        chk("b_trig",  O_seq_trigger, 1);
        chk("b_done",  O_done, 1);
        chk("b_arm0",  O_arm, 0);
        chk("b_cnt",   O_match_cnt, 1);
        chk("b_clr",   O_match_clear, 1);
        step();
        chk("b_trig0", O_seq_trigger, 0);
        I_match = 1'b0;
        step();

        // Multi-match with holdoff 5: arm low 6 cycles per counted match
        cfg(8'd3, 16'd5, 32'd0, 1'b0);
        arm();
        chk("m_flush", O_match_clear, 1);
        chk("m_cnt0",  O_match_cnt, 0);
        cyc(3);
        for (int m = 1; m <= 3; m++) begin
            match_pulse();
            chk("m_cnt", O_match_cnt, 32'(m));
            chk("m_trig", O_seq_trigger, (m == 3) ? 1 : 0);
            chk("m_clr", O_match_clear, 1);
            if (m < 3) begin
                for (int i = 0; i < 6; i++) begin
                    chk("m_hold_arm", O_arm, 0);
                    if (m == 1 && i == 1) I_match = 1'b1;
                    if (m == 1 && i == 2) I_match = 1'b0;
                    step();
                end
                chk("m_rearmed", O_arm, 1);
                chk("m_cnt_hold", O_match_cnt, 32'(m));
                cyc(2);
            end
        end
        chk("m_done", O_done, 1);
        step();

        // Timeout 100, target 2, one match only
        cfg(8'd2, 16'd0, 32'd100, 1'b0);
        arm();
        trig_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) I_match = 1'b1;
            if (k == 6) I_match = 1'b0;
            if (O_seq_trigger) trig_seen++;
            if (k == 100) begin
                chk("t_done99", O_done, 0);
                chk("t_busy99", O_busy, 1);
            end
            step();
        end
        chk("t_done",   O_done, 1);
        chk("t_flag",   O_timeout, 1);
        chk("t_notrig", trig_seen, 0);
        chk("t_cnt",    O_match_cnt, 1);
        arm();
        chk("t_clear",  O_timeout, 0);
        chk("t_cnt0",   O_match_cnt, 0);
        chk("t_arm",    O_arm, 1);

        // Auto-rearm: restart while busy, three triggers, never DONE
        cfg(8'd1, 16'd2, 32'd0, 1'b1);
        arm();
        cyc(2);
        trig_seen = 0;
        for (int m = 0; m < 3; m++) begin
            match_pulse();
            if (O_seq_trigger) trig_seen++;
            chk("a_cnt", O_match_cnt, 0);
            for (int i = 0; i < 4; i++) begin
                chk("a_busy", O_busy, 1);
                chk("a_done", O_done, 0);
                step();
                if (O_seq_trigger) trig_seen++;
            end
            chk("a_armed", O_arm, 1);
        end
        chk("a_trigs", trig_seen, 3);

        // Collision: completing match on the timeout expiry cycle
        cfg(8'd1, 16'd0, 32'd10, 1'b0);
        arm();
        cyc(9);
        chk("c_busy", O_busy, 1);
        I_match = 1'b1;
        step();
        chk("c_trig", O_seq_trigger, 1);
        chk("c_tout", O_timeout, 0);
        chk("c_done", O_done, 1);
        chk("c_cnt",  O_match_cnt, 1);
        I_match = 1'b0;
        step();

        // Disarm wins over a simultaneous arm request
        I_disarm = 1'b1; I_arm_req = 1'b1;
        step();
        I_disarm = 1'b0; I_arm_req = 1'b0;
        chk("d_done", O_done, 0);
        chk("d_busy", O_busy, 0);
        chk("d_arm",  O_arm, 0);
        chk("d_cnt",  O_match_cnt, 1);
        step();

        // Async reset in the middle of holdoff
        cfg(8'd2, 16'd20, 32'd0, 1'b0);
        arm();
        match_pulse();
        chk("r_busy_pre", O_busy, 1);
        chk("r_cnt_pre",  O_match_cnt, 1);
        cyc(2);
        reset_n = 1'b0;
        #1;
        chk("r_busy", O_busy, 0);
        chk("r_cnt",  O_match_cnt, 0);
        chk("r_arm",  O_arm, 0);
        chk("r_clr",  O_match_clear, 0);
        cyc(2);
        reset_n = 1'b1;
        step();
        match_pulse();
        chk("r_ign_cnt",  O_match_cnt, 0);
        chk("r_ign_busy", O_busy, 0);
        chk("r_ign_trig", O_seq_trigger, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pw_match_sequencer.md
Name: pw_match_sequencer

Overview:
- Controller for the USB pattern matcher, running in the front-end clock domain.
- Sequences matcher arming: it counts N qualifying matches (with holdoff between them) before firing a sequence trigger.
- Enforces an optional armed-window timeout, auto re-arms when configured, and reports status to the register block.
- Drives the matcher's arm input and clears its sticky match flag after each counted match.

Parameters:
- pCNT_WIDTH, 8: width of match-count target and counter.
- pHOLDOFF_WIDTH, 16: width of holdoff cycle counter.
- pTIMEOUT_WIDTH, 32: width of timeout cycle counter.

Ports:
- fe_clk  in  1  front-end clock; single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- I_arm_req  in  1  single-cycle pulse: start a sequence (already synchronized to fe_clk).
- I_disarm  in  1  single-cycle pulse: abort, return to IDLE.
- I_match_target  in  pCNT_WIDTH  matches required per trigger; 0 treated as 1.
- I_holdoff_cycles  in  pHOLDOFF_WIDTH  cycles matcher stays disarmed after each counted match.
- I_timeout_cycles  in  pTIMEOUT_WIDTH  max cycles from arm to trigger; 0 = disabled.
- I_auto_rearm  in  1  after trigger, restart sequence instead of stopping.
- I_match  in  1  matcher match flag (level, sticky until cleared).
- O_arm  out  1  arm to matcher.
- O_match_clear  out  1  one-cycle pulse clearing matcher's match flag.
- O_seq_trigger  out  1  one-cycle pulse: sequence complete.
- O_match_cnt  out  pCNT_WIDTH  matches counted in current sequence.
- O_busy  out  1  state is ARMED or HOLDOFF.
- O_done  out  1  state is DONE.
- O_timeout  out  1  sticky timeout flag, cleared by next I_arm_req.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0; all counters 0.
- Config latch: I_match_target, I_holdoff_cycles, I_timeout_cycles and I_auto_rearm are latched on the cycle I_arm_req is accepted. Mid-sequence changes have no effect.
- Match event: I_match & !match_r, where match_r is I_match registered. Events are only honoured in ARMED.
- All outputs are registered. O_arm = (state==ARMED).
- IDLE:
  - I_arm_req -> ARMED.
  - Clear match count and O_timeout; load timeout counter.
- ARMED, on a match event:
  - Increment count; pulse O_match_clear next cycle.
  - If the new count == target: pulse O_seq_trigger on the same cycle.
    - If auto_rearm: count <- 0, timeout reloaded, go HOLDOFF.
    - Otherwise go DONE.
  - If the new count < target: go HOLDOFF.
  - Trigger latency: O_seq_trigger high exactly 1 cycle after the I_match rising edge.
- HOLDOFF:
  - O_arm=0; load holdoff counter on entry; decrement each cycle.
  - Return to ARMED on the cycle the counter reads 0. Holdoff 0 means exactly 1 cycle in HOLDOFF.
  - Matches seen here are ignored, but match_r still tracks I_match.
- Timeout:
  - Counter decrements in ARMED and HOLDOFF when enabled.
  - On reaching 0: go DONE, set O_timeout, no O_seq_trigger.
  - If a completing match event and timeout expiry land in the same cycle, the match wins and O_timeout stays 0.
- DONE:
  - O_done=1, O_arm=0.
  - I_arm_req -> ARMED with fresh latch and clears. I_disarm -> IDLE.
- Priority: I_disarm > I_arm_req > match/timeout.
  - I_disarm in any state -> IDLE next cycle. O_match_cnt and O_timeout are held for readback; O_arm drops next cycle.
  - I_arm_req while busy restarts the sequence: count 0, timeouts reloaded, config re-latched.
- Width rules:
  - Counters saturate; no wrap.
  - Count compare is done at pCNT_WIDTH; target 0 maps to 1 before compare.
- O_match_clear also pulses on entry to ARMED from IDLE/DONE, to flush a stale match.

Decomposition:
- Shared package (pw_defines):
  - State encoding constants PMS_IDLE, PMS_ARMED, PMS_HOLDOFF, PMS_DONE.
  - Default widths.
- One sub-module, pw_loadable_downcounter (load, enable, zero flag; parameterized width), instanced for holdoff and timeout.
- FSM, edge detect and match counter stay in the top level.

Test Plan:
- Basic: target=1, holdoff=0, timeout=0; arm, raise I_match at cycle 10 -> O_seq_trigger at cycle 11, O_done=1, O_arm=0, O_match_cnt=1.
- Multi-match holdoff: target=3, holdoff=5; match pulses at 10, 12 (ignored, in holdoff), 20, 30 -> O_match_cnt 1,2,3; single O_seq_trigger after the 30 edge; O_arm low 6 cycles after each counted match.
- Timeout: target=2, timeout=100, one match only -> DONE at cycle 100 after arm, O_timeout=1, no trigger; next I_arm_req clears O_timeout.
- Auto-rearm: target=1, auto_rearm=1, holdoff=2; three matches -> three O_seq_trigger pulses; O_busy stays 1; O_done never asserts.
- Collision: completing match on the same cycle as timeout expiry -> trigger fires and O_timeout=0. I_disarm together with I_arm_req -> IDLE.
- Async reset asserted mid-HOLDOFF -> all outputs 0 immediately; state IDLE after release; I_match ignored until the next arm.
